// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter.
//   uart_state_e  : frame-level state encoding (IDLE/START/DATA/STOP)
//   UART_MAX_BITS : largest supported data word length in bits
//   UART_CNT_W    : width of a bit-position counter covering 0..UART_MAX_BITS
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_MAX_BITS = 16;
    localparam int unsigned UART_CNT_W    = $clog2(UART_MAX_BITS) + 1;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset, loads RESET_VAL into both flops
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clk_i cycles behind d_i
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, 1..16 data bits (LSB first), 1 stop bit, sampled
// on an OVERSAMPLE x baud clock enable. Received words are offered to the host
// with a valid/read handshake; framing and overrun errors are sticky flags.
//   clk_100m      : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   rx            : serial line (asynchronous, idles high)
//   clken         : one-cycle tick at OVERSAMPLE x baud
//   bits_per_word : index of last data bit (word length = value + 1)
//   rd_en         : host read strobe, consumes data_out
//   data_out      : last received word, zero-extended
//   rx_valid      : data_out holds an unread word
//   rx_busy       : a frame is in progress
//   frame_err     : sticky, stop bit was sampled low
//   overrun       : sticky, a word arrived while the previous was unread
//   err_clr       : clears frame_err and overrun
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              clken,
    input  logic [4:0]        bits_per_word,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_valid,
    output logic              rx_busy,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr
);

    localparam int unsigned      TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);

    logic rx_s;

    uart_state_e           state_q,   state_d;
    logic [TICK_W-1:0]     tick_q,    tick_d;
    logic [UART_CNT_W-1:0] bit_pos_q, bit_pos_d;
    logic [DATA_W-1:0]     shift_q,   shift_d;
    logic [DATA_W-1:0]     data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  ferr_q,    ferr_d;
    logic                  ovr_q,     ovr_d;

    logic word_done;
    logic stop_low;
    logic ovr_set;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk_i  (clk_100m),
        .rst_ni (rst_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_pos_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_pos_q <= bit_pos_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Frame FSM: every state/counter advance is gated by clken.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_pos_d = bit_pos_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        stop_low  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clken && !rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end

            START: begin
                if (clken) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_pos_d = '0;
                            shift_d   = '0;
                        end else begin
                            // Line back high at mid start bit: treat as a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            DATA: begin
                if (clken) begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        for (int unsigned i = 0; i < DATA_W; i++) begin
                            if (UART_CNT_W'(i) == bit_pos_q) begin
                                shift_d[i] = rx_s;
                            end
                        end
                        if (bit_pos_q == bits_per_word) begin
                            state_d = STOP;
                        end else begin
                            bit_pos_d = bit_pos_q + UART_CNT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            STOP: begin
                if (clken) begin
                    if (tick_q == TICK_END) begin
                        tick_d    = '0;
                        word_done = 1'b1;
                        stop_low  = !rx_s;
                        state_d   = IDLE;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Host handshake and sticky flags; these act on any cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_set = 1'b0;

        if (word_done) begin
            // A read landing on the completion cycle consumes the old word,
            // so only an unread word is overrun.
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_set = valid_q && !rd_en;
        end else if (rd_en) begin
            valid_d = 1'b0;
        end

        ferr_d = ferr_q;
        if (stop_low) begin
            ferr_d = 1'b1;
        end else if (err_clr) begin
            ferr_d = 1'b0;
        end

        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (err_clr) begin
            ovr_d = 1'b0;
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule : uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. It is the receive-side counterpart of the serial transmitter already in the peripheral set.
- Recovers LSB-first asynchronous frames of 1 start bit, 1..16 data bits and 1 stop bit from the rx pin, sampled at OVERSAMPLE × baud.
- Presents the received word with a valid/read handshake to the bus-side register logic. Flags framing and overrun errors.
- Shares the baud-tick generator with the transmitter. The only difference is that this block is fed the oversampled tick.

Parameters:
- DATA_W, 16, width of the data_out word.
- OVERSAMPLE, 16, clken ticks per bit period; power of two, minimum 8.

Ports:
- clk_100m  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk_100m, idles high.
- clken  input  1  single-cycle tick at OVERSAMPLE × baud.
- bits_per_word  input  5  index of the last data bit; word length = bits_per_word+1; legal range 0..15.
- rd_en  input  1  single-cycle read strobe from the host; consumes data_out.
- data_out  output  16  last received word, zero-extended above bit bits_per_word.
- rx_valid  output  1  data_out holds an unread word.
- rx_busy  output  1  high while state != IDLE.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun  output  1  sticky; a word completed while rx_valid was already high.
- err_clr  input  1  single-cycle strobe; clears frame_err and overrun.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_out=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - State=IDLE, tick and bit counters=0.
  - Synchronizer flops preset to 1 (line idle).
  - Reset mid-frame abandons the frame. No partial word is ever presented.
- Input conditioning:
  - rx passes through a 2-flop synchronizer; rx_s is the synchronized value.
  - Only rx_s is used internally, so line-to-state latency is 2 clk_100m cycles.
- All state and counter advances occur only on cycles with clken=1. The exceptions are the handshake and flag clears, which act on any cycle.
- IDLE:
  - On clken with rx_s=0: go to START, tick counter=0.
- START:
  - Count ticks. At tick OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA, bit_pos=0, tick counter=0, shift register cleared.
  - rx_s=1: false start (glitch). Return to IDLE with no flag set.
- DATA:
  - At tick OVERSAMPLE-1 (mid bit), store rx_s into shift[bit_pos] and reset the tick counter.
  - If bit_pos==bits_per_word, go to STOP; else bit_pos+1.
  - bits_per_word is sampled live. Changing it mid-frame is illegal; the bench does not exercise it.
- STOP:
  - At tick OVERSAMPLE-1, sample rx_s.
  - rx_s=0: set frame_err; the word is still delivered.
  - In both cases, on the same cycle: data_out<=shift and rx_valid<=1.
  - If rx_valid was already 1 and rd_en is not high this cycle, set overrun; the new word overwrites data_out.
  - Go to IDLE. The next start bit is accepted from the next clken, even if the line is still low after a framing error.
- Latency: data_out and rx_valid update on the clk_100m edge of the mid-stop-bit clken, 2 cycles after the line value is observed.
- Handshake:
  - rd_en with rx_valid=1 clears rx_valid on the next edge.
  - rd_en coincident with a new word: new word is loaded, rx_valid stays 1, no overrun.
  - rd_en with rx_valid=0: no effect.
- Flags:
  - err_clr clears frame_err and overrun.
  - Same-cycle set and err_clr: set wins.
- Bit counter is 5 bits and never wraps past bits_per_word, since the value is at most 15.
- Default or illegal state encoding returns to IDLE with no output change.

Decomposition:
- Shared package uart_pkg holds:
  - Shared state encodings IDLE/START/DATA/STOP, also reused by the transmitter.
  - UART_MAX_BITS=16.
- One natural sub-module: sync_2ff (rx synchronizer, reset value parameterized, here 1).
- Everything else stays inline: tick counter, FSM, shift register, flags.

Test Plan:
- 8-bit frame: bits_per_word=7, send 0xA5 with clean stop -> data_out=0x00A5, rx_valid=1, frame_err=0; rd_en then clears rx_valid the next cycle.
- 16-bit frame: bits_per_word=15, send 0xBEEF, then bits_per_word=4, send 0x13 -> data_out=0xBEEF, then 0x0013, no errors.
- Glitch: rx low for 3 clken ticks, then high -> stays/returns IDLE, rx_valid=0, rx_busy drops within OVERSAMPLE/2 ticks.
- Framing error: 8-bit 0x3C with stop bit low -> data_out=0x003C, rx_valid=1, frame_err=1; err_clr -> frame_err=0.
- Overrun: two back-to-back frames 0x11, 0x22 with no rd_en -> data_out=0x0022, overrun=1. Repeat with rd_en on the completion cycle of the second frame -> overrun=0.
- Reset mid-frame: assert rst_n low during DATA bit 3 of 0xFF -> all outputs 0 immediately. After release, next frame 0x5A is received correctly.
